// File: rtl/nr_bit_interleaver_if.sv
// Handshake and data bundle for the NR bit interleaver.
// The master side is the rate-matching producer and the output consumer.
interface nr_bit_interleaver_if;
  logic        start;
  logic [16:0] E;
  logic [3:0]  Qm;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic        out_bit;
  logic        out_valid;
  logic        done;
  logic        err;

  modport master (
    output start, E, Qm, in_bit, in_valid,
    input  in_ready, out_bit, out_valid, done, err
  );

  modport slave (
    input  start, E, Qm, in_bit, in_valid,
    output in_ready, out_bit, out_valid, done, err
  );
endinterface

// File: rtl/nr_bit_interleaver.sv
// NR row-column bit interleaver: buffers E serial bits, then reads them out
// column-wise so that f[i + j*Qm] = e[i*C + j] with C = E/Qm.
module nr_bit_interleaver #(
  parameter int unsigned MAX_E  = 16384,
  parameter int unsigned ADDR_W = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  nr_bit_interleaver_if.slave  bus
);

  localparam int unsigned CNT_W = 17;
  localparam int unsigned QM_W  = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    e_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    c_q;
  logic [CNT_W-1:0]    j_q;
  logic [QM_W-1:0]     qm_q;
  logic [QM_W-1:0]     sub_q;
  logic [QM_W-1:0]     i_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                in_ready_q;
  logic                out_bit_q;
  logic                out_valid_q;
  logic                done_q;
  logic                err_q;

  logic                mem [DEPTH];

  logic                cfg_ok;
  logic                accept;
  logic                last_cnt;
  logic                sub_wrap;
  logic                i_wrap;
  logic [QM_W-1:0]     sub_d;
  logic [CNT_W-1:0]    c_d;
  logic [CNT_W-1:0]    j_inc;

  // Configuration legality and per-cycle counter helpers.
  always_comb begin
    cfg_ok   = (bus.Qm == 4'd1 || bus.Qm == 4'd2 || bus.Qm == 4'd4 ||
                bus.Qm == 4'd6 || bus.Qm == 4'd8) &&
               (bus.E != 17'd0) && (bus.E <= CNT_W'(MAX_E));
    accept   = in_ready_q & bus.in_valid;
    last_cnt = (cnt_q == e_q - 17'd1);
    sub_wrap = (sub_q == qm_q - 4'd1);
    sub_d    = sub_wrap ? 4'd0 : sub_q + 4'd1;
    c_d      = sub_wrap ? c_q + 17'd1 : c_q;
    i_wrap   = (i_q == qm_q - 4'd1);
    j_inc    = j_q + 17'd1;
  end

  // Bit buffer write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[cnt_q[ADDR_W-1:0]] <= bus.in_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      e_q         <= '0;
      cnt_q       <= '0;
      c_q         <= '0;
      j_q         <= '0;
      qm_q        <= '0;
      sub_q       <= '0;
      i_q         <= '0;
      rd_addr_q   <= '0;
      in_ready_q  <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The cycle carrying the final out_valid/done still refuses a start.
          if (bus.start && !out_valid_q) begin
            if (cfg_ok) begin
              e_q        <= bus.E;
              qm_q       <= bus.Qm;
              cnt_q      <= '0;
              sub_q      <= '0;
              c_q        <= '0;
              i_q        <= '0;
              j_q        <= '0;
              rd_addr_q  <= '0;
              in_ready_q <= 1'b1;
              state_q    <= FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        FILL: begin
          if (accept) begin
            cnt_q <= cnt_q + 17'd1;
            sub_q <= sub_d;
            c_q   <= c_d;
            if (last_cnt) begin
              in_ready_q <= 1'b0;
              cnt_q      <= '0;
              if (sub_d == 4'd0) begin
                state_q <= DRAIN;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
        end

        DRAIN: begin
          // Synchronous read lands directly in the output register.
          out_bit_q   <= mem[rd_addr_q];
          out_valid_q <= 1'b1;
          cnt_q       <= cnt_q + 17'd1;
          if (last_cnt) begin
            done_q    <= 1'b1;
            cnt_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            rd_addr_q <= '0;
            state_q   <= IDLE;
          end else if (i_wrap) begin
            i_q       <= '0;
            j_q       <= j_inc;
            rd_addr_q <= ADDR_W'(j_inc);
          end else begin
            i_q       <= i_q + 4'd1;
            rd_addr_q <= rd_addr_q + ADDR_W'(c_q);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_nr_bit_interleaver.sv
// Scoreboard bench for nr_bit_interleaver: a reference permutation queues the
// expected output order, a negedge monitor pops and compares each out_bit.
module tb_nr_bit_interleaver;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   out_cnt;
  int   first_cyc;
  logic prev_ov;
  bit   ebits[$];
  bit   exp_q[$];

  nr_bit_interleaver_if bus ();

  nr_bit_interleaver #(.MAX_E(16384), .ADDR_W(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every out_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (prev_ov !== 1'b1) first_cyc = cyc;
      out_cnt++;
      if (exp_q.size() == 0) begin
        chk_eq("spurious_out", 32'd1, 32'd0);
      end else begin
        chk_eq("out_bit", 32'(bus.out_bit), 32'(exp_q.pop_front()));
        chk_eq("done", 32'(bus.done), 32'(exp_q.size() == 0));
      end
    end else if (bus.done === 1'b1) begin
      chk_eq("done_alone", 32'd1, 32'd0);
    end
    prev_ov = bus.out_valid;
  end

  task automatic run_block(input int e_len, input int qm, input bit gaps,
                           input bit expect_ok, input bit poke_start, input int abort_after);
    int c;
    int k;
    int g;
    int last_acc;
    int base;
    bit acc;
    if (expect_ok) begin
      c = e_len / qm;
      for (int j = 0; j < c; j++)
        for (int i = 0; i < qm; i++)
          exp_q.push_back(ebits[i*c + j]);
    end
    base = out_cnt;
    bus.start = 1'b1;
    bus.E     = 17'(e_len);
    bus.Qm    = 4'(qm);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.E     = 17'd3;
    bus.Qm    = 4'd8;
    k = 0;
    g = 0;
    last_acc = 0;
    while (k < e_len && g < 2000) begin
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_bit   = bus.in_valid ? ebits[k] : 1'($urandom_range(0, 1));
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        last_acc = cyc;
      end
      g++;
    end
    bus.in_valid = 1'b0;
    chk_eq("fill_count", 32'(k), 32'(e_len));
    if (!expect_ok) begin
      chk_eq("err_mod", 32'(bus.err), 32'd1);
      chk_eq("rdy_after_err", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      chk_eq("err_one_cycle", 32'(bus.err), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk_eq("no_out_after_err", 32'(out_cnt - base), 32'd0);
      return;
    end
    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      if (abort_after > 0 && (out_cnt - base) >= abort_after) begin
        rst = 1'b1;
        #1;
        chk_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk_eq("abort_done", 32'(bus.done), 32'd0);
        chk_eq("abort_out_bit", 32'(bus.out_bit), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_eq("abort_count", 32'(out_cnt - base), 32'(abort_after));
        break;
      end
      @(posedge clk); #1;
      g++;
      if (poke_start && g == 2) begin
        bus.start = 1'b1;
        bus.E     = 17'd12;
        bus.Qm    = 4'd6;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk_eq("drain_left", 32'(exp_q.size()), 32'd0);
    if (abort_after == 0) begin
      // First out_valid appears two cycles after the cycle accepting the last bit.
      chk_eq("latency", 32'(first_cyc - last_acc), 32'd1);
      chk_eq("out_total", 32'(out_cnt - base), 32'(e_len));
    end
    repeat (3) @(posedge clk);
    #1;
    chk_eq("idle_rdy", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic reject_start(input int e_len, input int qm);
    bus.start = 1'b1;
    bus.E     = 17'(e_len);
    bus.Qm    = 4'(qm);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk_eq("rej_err", 32'(bus.err), 32'd1);
    chk_eq("rej_rdy", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk_eq("rej_err_pulse", 32'(bus.err), 32'd0);
    chk_eq("rej_rdy_stays", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic set_bits(input int n, input int mode);
    ebits.delete();
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       ebits.push_back(k % 2 == 1);
        default: ebits.push_back(1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    out_cnt = 0;
    first_cyc = 0;
    prev_ov = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.E = '0;
    bus.Qm = '0;
    bus.in_bit = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("rst_out_bit", 32'(bus.out_bit), 32'd0);
    chk_eq("rst_done", 32'(bus.done), 32'd0);
    chk_eq("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Stray in_valid while idle must not open a block.
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk_eq("idle_valid_ignored", 32'(bus.in_ready), 32'd0);

    ebits = '{1, 1, 1, 1, 0, 0, 0, 0};
    run_block(8, 2, 1'b0, 1'b1, 1'b1, 0);

    set_bits(12, 0);
    run_block(12, 6, 1'b0, 1'b1, 1'b0, 0);
    run_block(12, 6, 1'b1, 1'b1, 1'b0, 0);

    ebits = '{1, 0, 1, 1, 0};
    run_block(5, 1, 1'b1, 1'b1, 1'b0, 0);

    set_bits(10, 1);
    run_block(10, 4, 1'b0, 1'b0, 1'b0, 0);

    reject_start(12, 3);
    reject_start(0, 2);
    reject_start(16385, 1);

    set_bits(16, 1);
    run_block(16, 4, 1'b0, 1'b1, 1'b0, 5);
    repeat (2) @(posedge clk);
    #1;

    ebits = '{1, 1, 1, 1, 0, 0, 0, 0};
    run_block(8, 2, 1'b0, 1'b1, 1'b0, 0);

    set_bits(48, 1);
    run_block(48, 8, 1'b1, 1'b1, 1'b0, 0);
    set_bits(60, 1);
    run_block(60, 6, 1'b0, 1'b1, 1'b0, 0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
